operand_entry_fsm: RTL

Upstream input stage of the ALU calculator. It turns four slide switches and two push buttons into the registered operand A, operand B and Opcode consumed by the ALU datapath. Entry is sequential: the user sets the switches and presses Enter three times, once each for A, B and Opcode. The block synchronizes and debounces the buttons, sequences entry with a state machine, and flags completion and out-of-range opcodes.

---
 rtl/calc_pkg.sv | 30 +++
 rtl/operand_entry_fsm_button_debouncer.sv | 48 ++++
 rtl/operand_entry_fsm.sv | 130 +++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the ALU calculator front end.
//   entry_state_t : operand entry sequence, encoding drives the state LEDs
//   OPCODE_MAX    : largest opcode the ALU implements
//   OP_*          : opcode values shared with the ALU datapath
package calc_pkg;

    typedef enum logic [1:0] {
        S_A     = 2'd0,
        S_B     = 2'd1,
        S_OP    = 2'd2,
        S_READY = 2'd3
    } entry_state_t;

    localparam logic [3:0] OPCODE_MAX = 4'b1100;

    localparam logic [3:0] OP_INC_A = 4'd0;
    localparam logic [3:0] OP_INC_B = 4'd1;
    localparam logic [3:0] OP_DEC_A = 4'd2;
    localparam logic [3:0] OP_DEC_B = 4'd3;
    localparam logic [3:0] OP_ADD   = 4'd4;
    localparam logic [3:0] OP_SUB   = 4'd5;
    localparam logic [3:0] OP_MUL   = 4'd6;
    localparam logic [3:0] OP_SHL_A = 4'd7;
    localparam logic [3:0] OP_SHR_A = 4'd8;
    localparam logic [3:0] OP_NOT_A = 4'd9;
    localparam logic [3:0] OP_AND   = 4'd10;
    localparam logic [3:0] OP_OR    = 4'd11;
    localparam logic [3:0] OP_XOR   = 4'd12;

endpackage

// File: rtl/operand_entry_fsm_button_debouncer.sv
// Push-button conditioner: 2-flop synchronizer, counter debouncer and a
// registered one-cycle pulse on each debounced press (releases are silent).
//   clk         : system clock
//   reset       : asynchronous, active-high
//   btn_raw     : raw bouncy button, active-high
//   press_pulse : one cycle high per debounced press
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic press_pulse
);

    localparam int CNT_W = ($clog2(DEBOUNCE_CYCLES) > 0) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             level_q;
    logic             level_prev_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q       <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= '0;
            press_pulse  <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], btn_raw};
            level_prev_q <= level_q;
            press_pulse  <= level_q & ~level_prev_q;
            // Any glitch back to the accepted level restarts the count,
            // so a flip needs DEBOUNCE_CYCLES consecutive differing samples.
            if (sync_q[1] == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                level_q <= sync_q[1];
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/operand_entry_fsm.sv
// Operand entry stage of the ALU calculator. Switches are synchronized,
// buttons synchronized and debounced; each Enter press captures the next
// of A, B, Opcode. Clear aborts entry from any state and wins over Enter.
//   clk, reset     : system clock, asynchronous active-high reset
//   sw             : raw slide switches
//   btn_enter      : raw Enter button
//   btn_clear      : raw Clear button
//   A, B, Opcode   : captured operands / opcode
//   operands_valid : complete set captured
//   load_pulse     : one-cycle strobe on the rise of operands_valid
//   opcode_err     : captured Opcode above OPCODE_MAX
//   entry_state    : current entry state for the LEDs
module operand_entry_fsm
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int DATA_W          = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] sw,
    input  logic              btn_enter,
    input  logic              btn_clear,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [DATA_W-1:0] Opcode,
    output logic              operands_valid,
    output logic              load_pulse,
    output logic              opcode_err,
    output logic [1:0]        entry_state
);

    logic [DATA_W-1:0] sw_meta_q, sw_sync_q;
    logic              enter_ev, clear_ev;

    entry_state_t      state_q, state_d;
    logic [DATA_W-1:0] a_d, b_d, op_d;
    logic              valid_d, load_d, err_d;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_enter (
        .clk         (clk),
        .reset       (reset),
        .btn_raw     (btn_enter),
        .press_pulse (enter_ev)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
        .clk         (clk),
        .reset       (reset),
        .btn_raw     (btn_clear),
        .press_pulse (clear_ev)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            sw_meta_q <= sw;
            sw_sync_q <= sw_meta_q;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = A;
        b_d     = B;
        op_d    = Opcode;
        valid_d = operands_valid;
        err_d   = opcode_err;
        load_d  = 1'b0;
        if (clear_ev) begin
            state_d = S_A;
            a_d     = '0;
            b_d     = '0;
            op_d    = '0;
            valid_d = 1'b0;
            err_d   = 1'b0;
        end else if (enter_ev) begin
            unique case (state_q)
                S_A: begin
                    a_d     = sw_sync_q;
                    state_d = S_B;
                end
                S_B: begin
                    b_d     = sw_sync_q;
                    state_d = S_OP;
                end
                S_OP: begin
                    // Out-of-range opcodes are still captured; only flagged.
                    op_d    = sw_sync_q;
                    err_d   = int'(sw_sync_q) > int'(OPCODE_MAX);
                    valid_d = 1'b1;
                    load_d  = 1'b1;
                    state_d = S_READY;
                end
                S_READY: begin
                    // Captured values linger until overwritten by new entry.
                    valid_d = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_A;
                end
                default: state_d = S_A;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_A;
            A              <= '0;
            B              <= '0;
            Opcode         <= '0;
            operands_valid <= 1'b0;
            load_pulse     <= 1'b0;
            opcode_err     <= 1'b0;
        end else begin
            state_q        <= state_d;
            A              <= a_d;
            B              <= b_d;
            Opcode         <= op_d;
            operands_valid <= valid_d;
            load_pulse     <= load_d;
            opcode_err     <= err_d;
        end
    end

    assign entry_state = state_q;

endmodule
